scla_addsub_pipe: RTL
=====================

Name: scla_addsub_pipe

Overview:
- Parametrised, pipelined signed adder/subtractor built from 4-bit carry-lookahead blocks, with the carry chain split across register stages.
- Per-operation add/sub select, signed overflow detection, optional saturation, and valid/ready flow control.
- Serves as the general-width arithmetic unit for the datapath; replaces fixed 4-bit lookahead add/sub slices.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4, minimum 8.
- STAGE_BLKS, 2, number of 4-bit lookahead blocks resolved per pipeline stage; NBLK = WIDTH/4, NSTAGE = ceil(NBLK/STAGE_BLKS).
- SAT_EN, 1, 1 = saturation logic present; 0 = sat input ignored, result always wraps.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B.
- sub  in  1  0 = A+B, 1 = A-B.
- sat  in  1  saturate on signed overflow (used only when SAT_EN=1).
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  signed sum/difference.
- cout  out  1  raw carry out of the MSB block; for sub, 1 = no borrow.
- overflow  out  1  signed overflow of the raw operation.
- zero  out  1  result == 0, evaluated after saturation.

Behaviour:
- Reset: all stage valid bits, out_valid, result, cout, overflow and zero clear to 0 asynchronously. in_ready is 1 while rst is low and the pipe is empty. Reset mid-stream discards all in-flight beats.
- Arithmetic: b_eff = sub ? ~b : b; cin = sub. Per block, g/p are computed per bit and the 4-bit lookahead produces the internal carries and block G/P. Blocks within a stage are chained through lookahead on block G/P. The carry out of the top block of a stage is registered into the next stage.
- Skew: operand bits of blocks not yet processed are delayed with their beat. Low result bits already computed are carried forward, so each output beat is bit-consistent.
- Latency: NSTAGE cycles from accepted input (in_valid & in_ready at edge k) to out_valid at edge k+NSTAGE when no stall occurs. Throughput is 1 beat per cycle.
- Flow control: global enable adv = out_ready | ~out_valid. in_ready = adv. All stages shift only when adv=1. Bubbles (in_valid=0 while adv=1) propagate as invalid stages and are not collapsed. While adv=0, every stage, including result/flags, holds stable.
- Overflow: overflow = (a[MSB] == b_eff[MSB]) & (raw[MSB] != a[MSB]), computed in the final stage from the delayed sign bits.
- Saturation: if SAT_EN & sat & overflow, result = a[MSB] ? {1,0...0} : {0,1...1}; otherwise result = raw. overflow and cout always report the raw operation. The sub and sat controls travel with the beat.
- Outputs: out_valid, result and flags are registered and change only when adv=1 or on rst. Values while out_valid=0 are don't-care, but the bench must not see X after reset.
- A beat presented while in_ready=0 is not consumed. The producer holds it until accepted.

Test Plan:
(WIDTH=16, STAGE_BLKS=2, NSTAGE=2, out_ready=1 unless stated)
- Add with cross-stage carry: a=0x00FF, b=0x0001, sub=0 -> result 0x0100, cout 0, overflow 0, zero 0, out_valid exactly 2 cycles after accept. a=0xFFFF, b=0x0001 -> 0x0000, cout 1, zero 1.
- Subtract: a=0x0005, b=0x0007, sub=1 -> 0xFFFE, cout 0, overflow 0. a=0x0007, b=0x0005 -> 0x0002, cout 1.
- Positive overflow: a=0x7FFF, b=0x0001, sub=0, sat=0 -> 0x8000, overflow 1. Same beat with sat=1 -> 0x7FFF, overflow 1.
- Negative overflow: a=0x8000, b=0x0001, sub=1, sat=0 -> 0x7FFF, overflow 1, cout 1. With sat=1 -> 0x8000. SAT_EN=0 build with sat=1 -> 0x7FFF.
- Backpressure stream: 8 back-to-back mixed beats, out_ready pattern 1,0,1,0,... -> all 8 results in order, none lost or duplicated. in_ready=0 exactly on cycles where out_valid=1 and out_ready=0. Result is stable while stalled.
- Reset mid-stream: rst pulsed (asynchronous, between edges) with 2 beats in flight -> out_valid drops to 0 immediately, those beats never appear. The first beat after release (0x1234+0x0FFF) -> 0x2233 at latency 2.

Source files
------------

// File: rtl/scla_addsub_pipe_if.sv
// scla_addsub_pipe_if
// Bundle of the operand and result streams for scla_addsub_pipe.
//   in_valid/in_ready : operand beat handshake (a, b, sub, sat travel with it)
//   out_valid/out_ready : result beat handshake (result, cout, overflow, zero)
// Handshake rule for both streams: a beat transfers on a rising clk edge where
// valid and ready are both 1; the producer holds valid and the payload stable
// until that edge, and ready may depend combinationally on the consumer side.
// Modports:
//   slave  - the arithmetic unit (consumes operands, produces results)
//   master - the surrounding logic (produces operands, consumes results)
interface scla_addsub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport slave (
        input  in_valid, a, b, sub, sat, out_ready,
        output in_ready, out_valid, result, cout, overflow, zero
    );

    modport master (
        output in_valid, a, b, sub, sat, out_ready,
        input  in_ready, out_valid, result, cout, overflow, zero
    );
endinterface

// File: rtl/scla_addsub_pipe.sv
// scla_addsub_pipe
// Pipelined signed adder/subtractor built from 4-bit carry-lookahead blocks.
// STAGE_BLKS blocks are resolved per pipeline stage; the carry out of the top
// block of a stage is registered into the next stage together with the
// still-unprocessed operand bits and the already-finished low result bits.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, discards every in-flight beat
//   bus  - slave side of scla_addsub_pipe_if (operand and result streams)
// Parameters:
//   WIDTH      - operand/result width, multiple of 4, at least 8
//   STAGE_BLKS - 4-bit blocks per pipeline stage
//   SAT_EN     - 1 builds the saturation mux, 0 always wraps
// Timing: operands accepted at edge k appear on the outputs at edge k+NSTAGE.
module scla_addsub_pipe #(
    parameter int WIDTH      = 16,
    parameter int STAGE_BLKS = 2,
    parameter bit SAT_EN     = 1'b1
) (
    input logic               clk,
    input logic               rst,
    scla_addsub_pipe_if.slave bus
);
    localparam int NBLK   = WIDTH / 4;
    localparam int NSTAGE = (NBLK + STAGE_BLKS - 1) / STAGE_BLKS;

    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    // 4-bit lookahead block: returns {G, P, sum[3:0]}.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] g, p, c;
        logic       bg, bp;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        bg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        bp   = &p;
        return {bg, bp, p ^ c};
    endfunction

    // Pipeline registers; index s holds a beat that has blocks of stages
    // 0..s-1 resolved. Index 0 is the operand capture register.
    logic [NSTAGE-1:0]            v_q;
    logic [NSTAGE-1:0][WIDTH-1:0] a_q;
    logic [NSTAGE-1:0][WIDTH-1:0] b_q;    // b already inverted for subtract
    logic [NSTAGE-1:0][WIDTH-1:0] s_q;    // raw sum bits resolved so far
    logic [NSTAGE-1:0]            c_q;    // carry into the next unresolved block
    logic [NSTAGE-1:0]            sat_q;

    // Output registers
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             overflow_q;
    logic             zero_q;

    // Combinational result of each stage's block group
    logic [NSTAGE-1:0][WIDTH-1:0] sum_n;
    logic [NSTAGE-1:0]            c_n;

    logic             adv;
    logic [WIDTH-1:0] raw;
    logic             a_msb;
    logic             b_msb;
    logic             ovf;
    logic             do_sat;
    logic [WIDTH-1:0] res;

    // Single global enable: the whole pipe moves or the whole pipe holds.
    assign adv = bus.out_ready | ~out_valid_q;

    always_comb begin : stage_comb
        logic       c;
        logic [5:0] blk_out;
        int         blk;
        sum_n   = '0;
        c_n     = '0;
        c       = 1'b0;
        blk_out = '0;
        blk     = 0;
        for (int s = 0; s < NSTAGE; s++) begin
            sum_n[s] = s_q[s];
            c        = c_q[s];
            // Blocks inside a stage chain on their G/P terms.
            for (int j = 0; j < STAGE_BLKS; j++) begin
                blk = s * STAGE_BLKS + j;
                if (blk < NBLK) begin
                    blk_out = cla4(a_q[s][blk*4 +: 4], b_q[s][blk*4 +: 4], c);
                    sum_n[s][blk*4 +: 4] = blk_out[3:0];
                    c = blk_out[5] | (blk_out[4] & c);
                end
            end
            c_n[s] = c;
        end
    end

    // Final stage: flags come from the delayed sign bits of the same beat.
    assign raw    = sum_n[NSTAGE-1];
    assign a_msb  = a_q[NSTAGE-1][WIDTH-1];
    assign b_msb  = b_q[NSTAGE-1][WIDTH-1];
    assign ovf    = (a_msb == b_msb) & (raw[WIDTH-1] != a_msb);
    assign do_sat = SAT_EN & sat_q[NSTAGE-1] & ovf;
    assign res    = do_sat ? (a_msb ? SAT_MIN : SAT_MAX) : raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            c_q         <= '0;
            sat_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            v_q[0]   <= bus.in_valid;
            a_q[0]   <= bus.a;
            b_q[0]   <= bus.sub ? ~bus.b : bus.b;
            s_q[0]   <= '0;
            c_q[0]   <= bus.sub;
            sat_q[0] <= bus.sat;
            for (int s = 1; s < NSTAGE; s++) begin
                v_q[s]   <= v_q[s-1];
                a_q[s]   <= a_q[s-1];
                b_q[s]   <= b_q[s-1];
                s_q[s]   <= sum_n[s-1];
                c_q[s]   <= c_n[s-1];
                sat_q[s] <= sat_q[s-1];
            end
            out_valid_q <= v_q[NSTAGE-1];
            result_q    <= res;
            cout_q      <= c_n[NSTAGE-1];
            overflow_q  <= ovf;
            zero_q      <= (res == '0);
        end
    end

    // Nothing is accepted while reset is held, so no beat can slip past it.
    assign bus.in_ready  = adv & ~rst;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
endmodule
